// File: rtl/vga_pkg.sv
// Shared VGA constants and timing bundle.
// 1024x768@60, 65 MHz pixel clock.
package vga_pkg;

  localparam int COUNT_W = 11;

  localparam int VISIBLE_WIDTH          = 1024;
  localparam int HORIZONTAL_FRONT_PORCH = 24;
  localparam int HORIZONTAL_SYNC_PULSE  = 136;
  localparam int FULL_WIDTH             = 1344;

  localparam int VISIBLE_HEIGHT         = 768;
  localparam int VERTICAL_FRONT_PORCH   = 3;
  localparam int VERTICAL_SYNC_PULSE    = 6;
  localparam int FULL_HEIGHT            = 806;

  localparam int HBLNK_START = VISIBLE_WIDTH;
  localparam int HSYNC_START = VISIBLE_WIDTH + HORIZONTAL_FRONT_PORCH;
  localparam int HSYNC_STOP  = HSYNC_START + HORIZONTAL_SYNC_PULSE;

  localparam int VBLNK_START = VISIBLE_HEIGHT;
  localparam int VSYNC_START = VISIBLE_HEIGHT + VERTICAL_FRONT_PORCH;
  localparam int VSYNC_STOP  = VSYNC_START + VERTICAL_SYNC_PULSE;

  typedef struct packed {
    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
  } vga_timing_t;

endpackage

// File: rtl/vga_timing.sv
// Free-running VGA raster counters with sync, blanking
// and line/frame strobes, all registered.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = VISIBLE_WIDTH,
  parameter int H_FP      = HORIZONTAL_FRONT_PORCH,
  parameter int H_SYNC    = HORIZONTAL_SYNC_PULSE,
  parameter int H_TOTAL   = FULL_WIDTH,
  parameter int V_VISIBLE = VISIBLE_HEIGHT,
  parameter int V_FP      = VERTICAL_FRONT_PORCH,
  parameter int V_SYNC    = VERTICAL_SYNC_PULSE,
  parameter int V_TOTAL   = FULL_HEIGHT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [COUNT_W-1:0] hcount,
  output logic [COUNT_W-1:0] vcount,
  output logic               hsync,
  output logic               vsync,
  output logic               hblnk,
  output logic               vblnk,
  output logic               line_start,
  output logic               frame_start
);

  localparam logic [COUNT_W-1:0] H_LAST =
    COUNT_W'(H_TOTAL - 1);
  localparam logic [COUNT_W-1:0] V_LAST =
    COUNT_W'(V_TOTAL - 1);
  localparam logic [COUNT_W-1:0] HB_ON =
    COUNT_W'(H_VISIBLE);
  localparam logic [COUNT_W-1:0] VB_ON =
    COUNT_W'(V_VISIBLE);
  localparam logic [COUNT_W-1:0] HS_ON =
    COUNT_W'(H_VISIBLE + H_FP);
  localparam logic [COUNT_W-1:0] HS_OFF =
    COUNT_W'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [COUNT_W-1:0] VS_ON =
    COUNT_W'(V_VISIBLE + V_FP);
  localparam logic [COUNT_W-1:0] VS_OFF =
    COUNT_W'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [COUNT_W-1:0] ONE =
    COUNT_W'(1);

  if (H_VISIBLE + H_FP + H_SYNC > H_TOTAL) begin : g_hchk
    $fatal(1, "vga_timing: horizontal timing overflow");
  end
  if (V_VISIBLE + V_FP + V_SYNC > V_TOTAL) begin : g_vchk
    $fatal(1, "vga_timing: vertical timing overflow");
  end

  logic [COUNT_W-1:0] h_nxt;
  logic [COUNT_W-1:0] v_nxt;

  always_comb begin
    h_nxt = hcount + ONE;
    v_nxt = vcount;
    if (hcount == H_LAST) begin
      h_nxt = '0;
      v_nxt = (vcount == V_LAST) ? '0 : vcount + ONE;
    end
  end

  // Flags decode the next count so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblnk       <= 1'b0;
      vblnk       <= 1'b0;
      line_start  <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      hcount      <= h_nxt;
      vcount      <= v_nxt;
      hsync       <= (h_nxt >= HS_ON) && (h_nxt < HS_OFF);
      vsync       <= (v_nxt >= VS_ON) && (v_nxt < VS_OFF);
      hblnk       <= (h_nxt >= HB_ON);
      vblnk       <= (v_nxt >= VB_ON);
      line_start  <= (h_nxt == '0);
      frame_start <= (h_nxt == '0) && (v_nxt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: frame-position model
// with randomized resets and interval measurements.
module tb_vga_timing;

  localparam int HV    = 1024;
  localparam int HFP   = 24;
  localparam int HSW   = 136;
  localparam int HT    = 1344;
  localparam int VV    = 6;
  localparam int VFP   = 2;
  localparam int VSW   = 3;
  localparam int VT    = 14;
  localparam int FRAME = HT * VT;
  localparam int NCYC  = 55000;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit hb;
    bit vb;
    bit ls;
    bit fs;
    bit r;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic        line_start;
  logic        frame_start;

  int tests_run = 0;
  int failed    = 0;

  exp_t q[$];

  vga_timing #(
    .V_VISIBLE(VV),
    .V_FP     (VFP),
    .V_SYNC   (VSW),
    .V_TOTAL  (VT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblnk      (hblnk),
    .vblnk      (vblnk),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Position p is the pixel index within the frame.
  function automatic exp_t model(int p, bit r);
    exp_t e;
    e.h  = p % HT;
    e.v  = p / HT;
    e.hs = (e.h >= HV + HFP) && (e.h < HV + HFP + HSW);
    e.vs = (e.v >= VV + VFP) && (e.v < VV + VFP + VSW);
    e.hb = (e.h >= HV);
    e.vb = (e.v >= VV);
    e.ls = (e.h == 0);
    e.fs = (p == 0);
    e.r  = r;
    return e;
  endfunction

  task automatic check(string name, int got, int need);
    tests_run++;
    if (got != need) begin
      failed++;
      $display("FAIL %s: got %0d need %0d", name, got, need);
    end
  endtask

  int  cyc = 0;
  int  line_gap = 0, frame_gap = 0;
  int  hs_cnt = 0, vs_cnt = 0;
  bit  line_ok = 0, frame_ok = 0;
  int  line_chk = 0, frame_chk = 0;

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      bit bad;
      e = q.pop_front();
      cyc++;
      tests_run++;
      bad = (int'(hcount) != e.h) || (int'(vcount) != e.v) ||
            (hsync !== e.hs) || (vsync !== e.vs) ||
            (hblnk !== e.hb) || (vblnk !== e.vb) ||
            (line_start !== e.ls) || (frame_start !== e.fs);
      if (bad) begin
        failed++;
        $display("FAIL cycle %0d: got h=%0d v=%0d hs%b vs%b hb%b vb%b ls%b fs%b need h=%0d v=%0d hs%b vs%b hb%b vb%b ls%b fs%b",
                 cyc, hcount, vcount, hsync, vsync, hblnk, vblnk,
                 line_start, frame_start, e.h, e.v, e.hs, e.vs,
                 e.hb, e.vb, e.ls, e.fs);
      end
      if (e.r) begin
        line_ok  = 0;
        frame_ok = 0;
      end
      line_gap++;
      frame_gap++;
      if (line_start === 1'b1) begin
        if (line_ok) begin
          check("line_period", line_gap, HT);
          check("hsync_width", hs_cnt, HSW);
          line_chk++;
        end
        line_ok  = 1;
        line_gap = 0;
        hs_cnt   = 0;
      end
      if (frame_start === 1'b1) begin
        if (frame_ok) begin
          check("frame_period", frame_gap, FRAME);
          check("vsync_cycles", vs_cnt, VSW * HT);
          frame_chk++;
        end
        frame_ok  = 1;
        frame_gap = 0;
        vs_cnt    = 0;
      end
      if (hsync === 1'b1) hs_cnt++;
      if (vsync === 1'b1) vs_cnt++;
    end
  end

  initial begin
    int  p;
    int  hold;
    bit  mid_done;
    p        = 0;
    hold     = 3;
    mid_done = 0;
    rst      = 1'b1;
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      p = rst ? 0 : (p + 1) % FRAME;
      q.push_back(model(p, rst));
      #1;
      if (hold > 0) hold--;
      if (!mid_done && p == 10 * HT + 500) begin
        hold     = 1;
        mid_done = 1;
      end
      if (hold == 0 && i > 52000 &&
          $urandom_range(0, 499) == 0)
        hold = $urandom_range(1, 3);
      rst = (hold > 0);
    end
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    check("mid_reset_seen", int'(mid_done), 1);
    check("line_checks_done", int'(line_chk > 30), 1);
    check("frame_checks_done", int'(frame_chk > 0), 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
